// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the multi-channel clock divider
package clk_div_pkg;
  localparam int P_CNT_W = 16;
  localparam int P_DEF_DIV = 10;
  localparam int P_DEF_HI = 5;
  localparam int MAX_CH = 8;
  localparam int CH_W = $clog2(MAX_CH);
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: configuration write bus for clk_div_multi
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = P_CNT_W
);
  logic load;
  logic [CH_W-1:0] load_ch;
  logic [CNT_W-1:0] load_div;
  logic [CNT_W-1:0] load_hi;
  modport master (output load, load_ch, load_div, load_hi);
  modport slave (input load, load_ch, load_div, load_hi);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with pending config applied at period wrap
module clk_div_chan #(
  parameter int CNT_W = 16,
  parameter int DEF_DIV = 10,
  parameter int DEF_HI = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic [CNT_W-1:0] wr_hi_i,
  output logic clk_o,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, hi_q, hi_d, pdiv_q, pdiv_d, phi_q, phi_d;
  logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, wrap, apply;
  // a write landing on the apply edge bypasses the pending registers
  always_comb begin
    wrap = cnt_q == div_q - CNT_W'(1);
    apply = !en_i || wrap;
    cnt_d = apply ? '0 : cnt_q + CNT_W'(1);
    clk_d = en_i && (cnt_q < hi_q);
    tick_d = en_i && (cnt_q == '0);
    div_d = !apply ? div_q : wr_i ? wr_div_i : pend_q ? pdiv_q : div_q;
    hi_d = !apply ? hi_q : wr_i ? wr_hi_i : pend_q ? phi_q : hi_q;
    pend_d = !apply && (wr_i || pend_q);
    pdiv_d = wr_i ? wr_div_i : pdiv_q;
    phi_d = wr_i ? wr_hi_i : phi_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DEF_DIV);
      hi_q <= CNT_W'(DEF_HI);
      pend_q <= 1'b0;
      pdiv_q <= CNT_W'(DEF_DIV);
      phi_q <= CNT_W'(DEF_HI);
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      hi_q <= hi_d;
      pend_q <= pend_d;
      pdiv_q <= pdiv_d;
      phi_q <= phi_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign clk_o = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock divider; top owns load decode,
// validation and the cfg_err pulse.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CNT_W = P_CNT_W,
  parameter int DEF_DIV = P_DEF_DIV,
  parameter int DEF_HI = P_DEF_HI
) (
  input  logic I_CLK,
  input  logic rst,
  input  logic [N_CH-1:0] en,
  clk_div_multi_if.slave cfg,
  output logic [N_CH-1:0] O_CLK,
  output logic [N_CH-1:0] O_TICK,
  output logic cfg_err
);
  logic ok, err_d, err_q;
  logic [CNT_W-1:0] hi_eff;
  // out-of-range high time falls back to 50% duty rather than erroring
  always_comb begin
    ok = (32'(cfg.load_ch) < N_CH) && (cfg.load_div >= CNT_W'(2));
    hi_eff = (cfg.load_hi == '0 || cfg.load_hi >= cfg.load_div) ? cfg.load_div >> 1 : cfg.load_hi;
    err_d = cfg.load && !ok;
  end
  always_ff @(posedge I_CLK) err_q <= rst ? 1'b0 : err_d;
  assign cfg_err = err_q;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W),
      .DEF_DIV(DEF_DIV),
      .DEF_HI(DEF_HI)
    ) u_chan (
      .clk(I_CLK),
      .rst(rst),
      .en_i(en[c]),
      .wr_i(cfg.load && ok && cfg.load_ch == CH_W'(c)),
      .wr_div_i(cfg.load_div),
      .wr_hi_i(hi_eff),
      .clk_o(O_CLK[c]),
      .tick_o(O_TICK[c])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: vector table, corner-case sequences and a randomized run
// checked against a period-start timestamp model.
module tb_clk_div_multi;
  localparam int N_CH = 2;
  localparam int CNT_W = 16;

  logic I_CLK = 1'b0;
  logic rst;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] O_CLK, O_TICK;
  logic cfg_err;
  int checks = 0;
  int failures = 0;

  clk_div_multi_if #(.CNT_W(CNT_W)) cfg ();

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(10), .DEF_HI(5)) dut (
    .I_CLK(I_CLK),
    .rst(rst),
    .en(en),
    .cfg(cfg),
    .O_CLK(O_CLK),
    .O_TICK(O_TICK),
    .cfg_err(cfg_err)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers the cycle its current period began;
  // the phase is just elapsed cycles since then.
  int cyc = 0;
  bit mv = 0;
  int m_start[N_CH], m_div[N_CH], m_hi[N_CH], m_pdiv[N_CH], m_phi[N_CH];
  bit m_pend[N_CH];
  logic [N_CH-1:0] e_clk, e_tick;
  logic e_err;

  always @(posedge I_CLK) begin
    int ph, ld, lh, wh;
    bit bad, w, bnd;
    ld = int'(cfg.load_div);
    lh = int'(cfg.load_hi);
    if (rst) begin
      mv = 1;
      e_clk = '0;
      e_tick = '0;
      e_err = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        m_start[c] = cyc + 1;
        m_div[c] = 10;
        m_hi[c] = 5;
        m_pend[c] = 0;
      end
    end else begin
      bad = cfg.load && (int'(cfg.load_ch) >= N_CH || ld < 2);
      e_err = bad;
      wh = (lh == 0 || lh >= ld) ? ld / 2 : lh;
      for (int c = 0; c < N_CH; c++) begin
        w = cfg.load && !bad && int'(cfg.load_ch) == c;
        if (en[c]) begin
          ph = cyc - m_start[c];
          e_clk[c] = ph < m_hi[c];
          e_tick[c] = ph == 0;
          bnd = ph == m_div[c] - 1;
        end else begin
          e_clk[c] = 1'b0;
          e_tick[c] = 1'b0;
          bnd = 1;
        end
        if (bnd) m_start[c] = cyc + 1;
        if (bnd && w) begin
          m_div[c] = ld;
          m_hi[c] = wh;
          m_pend[c] = 0;
        end else if (bnd && m_pend[c]) begin
          m_div[c] = m_pdiv[c];
          m_hi[c] = m_phi[c];
          m_pend[c] = 0;
        end else if (w) begin
          m_pend[c] = 1;
          m_pdiv[c] = ld;
          m_phi[c] = wh;
        end
      end
    end
    cyc++;
  end

  always @(negedge I_CLK) begin
    if (mv) begin
      chk("model_clk", 32'(O_CLK), 32'(e_clk));
      chk("model_tick", 32'(O_TICK), 32'(e_tick));
      chk("model_err", 32'(cfg_err), 32'(e_err));
    end
  end

  typedef struct {
    logic r;
    logic [1:0] en;
    logic ld;
    logic [2:0] ch;
    logic [15:0] dv;
    logic [15:0] hi;
    logic [1:0] eclk;
    logic [1:0] etick;
    logic eerr;
  } vec_t;
  vec_t tv[13];

  task automatic drive_load(input int ch, input int dv, input int hi);
    cfg.load = 1'b1;
    cfg.load_ch = 3'(ch);
    cfg.load_div = 16'(dv);
    cfg.load_hi = 16'(hi);
  endtask

  task automatic wait_tick(input int c);
    int n = 0;
    do begin
      @(negedge I_CLK);
      cfg.load = 1'b0;
      n++;
    end while (!O_TICK[c] && n < 200);
    if (!O_TICK[c]) begin
      checks++;
      failures++;
      $display("FAIL wait_tick ch%0d no tick within 200 cycles", c);
    end
  endtask

  // Called at a tick; counts cycles and high cycles until the next tick.
  task automatic period(input string nm, input int c, input int exp_per, input int exp_hi);
    int per = 1;
    int hi = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge I_CLK);
      cfg.load = 1'b0;
      if (O_TICK[c]) break;
      per++;
      if (O_CLK[c]) hi++;
    end
    chk({nm, "_per"}, 32'(per), 32'(exp_per));
    chk({nm, "_hi"}, 32'(hi), 32'(exp_hi));
  endtask

  initial begin
    rst = 1'b1;
    en = '0;
    cfg.load = 1'b0;
    cfg.load_ch = '0;
    cfg.load_div = '0;
    cfg.load_hi = '0;
    tv[0]  = '{1'b1, 2'b00, 1'b0, 3'd0, 16'd0, 16'd0, 2'b00, 2'b00, 1'b0};
    tv[1]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b01, 1'b0};
    tv[2]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b00, 1'b0};
    tv[3]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b00, 1'b0};
    tv[4]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b00, 1'b0};
    tv[5]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b00, 1'b0};
    tv[6]  = '{1'b0, 2'b01, 1'b1, 3'd0, 16'd1, 16'd0, 2'b00, 2'b00, 1'b1};
    tv[7]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b00, 2'b00, 1'b0};
    tv[8]  = '{1'b0, 2'b01, 1'b1, 3'd5, 16'd4, 16'd2, 2'b00, 2'b00, 1'b1};
    tv[9]  = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b00, 2'b00, 1'b0};
    tv[10] = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b00, 2'b00, 1'b0};
    tv[11] = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b01, 1'b0};
    tv[12] = '{1'b0, 2'b01, 1'b0, 3'd0, 16'd0, 16'd0, 2'b01, 2'b00, 1'b0};
    repeat (2) @(negedge I_CLK);
    for (int i = 0; i < 13; i++) begin
      rst = tv[i].r;
      en = tv[i].en;
      cfg.load = tv[i].ld;
      cfg.load_ch = tv[i].ch;
      cfg.load_div = tv[i].dv;
      cfg.load_hi = tv[i].hi;
      @(negedge I_CLK);
      chk($sformatf("tv%0d_clk", i), 32'(O_CLK), 32'(tv[i].eclk));
      chk($sformatf("tv%0d_tick", i), 32'(O_TICK), 32'(tv[i].etick));
      chk($sformatf("tv%0d_err", i), 32'(cfg_err), 32'(tv[i].eerr));
    end
    cfg.load = 1'b0;
    en = 2'b11;
    wait_tick(0);
    period("def_ch0", 0, 10, 5);
    wait_tick(1);
    drive_load(1, 4, 1);
    period("ch1_old", 1, 10, 5);
    period("ch1_new", 1, 4, 1);
    period("ch1_new2", 1, 4, 1);
    wait_tick(0);
    drive_load(0, 6, 9);
    period("ch0_old", 0, 10, 5);
    period("ch0_6_9", 0, 6, 3);
    wait_tick(0);
    repeat (4) @(negedge I_CLK);
    drive_load(0, 8, 2);
    wait_tick(0);
    period("wrap_ld", 0, 8, 2);
    period("wrap_ld2", 0, 8, 2);
    wait_tick(0);
    @(negedge I_CLK);
    rst = 1'b1;
    @(negedge I_CLK);
    rst = 1'b0;
    chk("rst_clk", 32'(O_CLK), 32'(0));
    chk("rst_tick", 32'(O_TICK), 32'(0));
    @(negedge I_CLK);
    chk("post_rst_tick", 32'(O_TICK[0]), 32'(1));
    chk("post_rst_clk", 32'(O_CLK[0]), 32'(1));
    period("post_rst", 0, 10, 5);
    for (int i = 0; i < 3000; i++) begin
      @(negedge I_CLK);
      rst = ($urandom % 300) == 0;
      if ($urandom % 25 == 0) en = 2'($urandom);
      cfg.load = ($urandom % 6) == 0;
      cfg.load_ch = 3'($urandom_range(0, 3));
      cfg.load_div = 16'($urandom_range(0, 14));
      cfg.load_hi = 16'($urandom_range(0, 16));
    end
    @(negedge I_CLK);
    rst = 1'b0;
    cfg.load = 1'b0;
    repeat (3) @(negedge I_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
